// File: rtl/spi_sram_pkg.sv
// Shared opcodes, mode encodings and FSM state type for the SPI serial-SRAM responder.
package spi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDMR  = 8'h05;
  localparam logic [7:0] CMD_WRMR  = 8'h01;

  // Mode register bits [7:6]; 2'b11 behaves as sequential.
  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;
  localparam logic [1:0] MODE_SEQ  = 2'b01;

  localparam int PAGE_SIZE = 32;
  localparam int PAGE_BITS = $clog2(PAGE_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_RDMR,
    ST_WRMR,
    ST_IGNORE
  } spi_tgt_state_t;

endpackage

// File: rtl/spi_sram_if.sv
// Four-wire SPI bus between the memory controller's master and the SRAM target.
interface spi_sram_if;
  logic sclk;
  logic ce;
  logic si;
  logic so;

  modport master (output sclk, output ce, output si, input so);
  modport slave  (input sclk, input ce, input si, output so);
endinterface

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for one asynchronous input plus rise/fall pulses from a third stage.
module spi_edge_sync (
  input  logic clk,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  // NOTE: synchronizer flops carry no reset, so a ce already low when reset
  // releases never produces a fall pulse and that transaction stays ignored.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[1:0], d};
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_sram_target.sv
// SPI mode-0 serial SRAM responder (READ/WRITE/RDMR/WRMR) oversampling the bus on clk.
module spi_sram_target
  import spi_sram_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  spi_sram_if.slave     spi,
  output logic          busy,
  input  logic [AW-1:0] bd_addr,
  output logic [7:0]    bd_data
);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic ce_level, ce_fall, ce_rise_unused;
  logic si_level, si_rise_unused, si_fall_unused;

  spi_edge_sync u_sync_sclk (.clk(clk), .d(spi.sclk), .level(sclk_level_unused),
                             .rise(sclk_rise), .fall(sclk_fall));
  spi_edge_sync u_sync_ce   (.clk(clk), .d(spi.ce), .level(ce_level),
                             .rise(ce_rise_unused), .fall(ce_fall));
  spi_edge_sync u_sync_si   (.clk(clk), .d(spi.si), .level(si_level),
                             .rise(si_rise_unused), .fall(si_fall_unused));

  // NOTE: the byte array has no reset; contents survive reset by design.
  logic [7:0] mem [DEPTH];

  spi_tgt_state_t state_q, state_d;
  logic [4:0]     bit_cnt;
  logic [6:0]     shift_in;
  logic [7:0]     out_shift;
  logic [AW-1:0]  addr;
  logic [1:0]     mode;
  logic           op_read;
  logic           so_q;
  logic           wr_en;

  logic [7:0]    data_byte;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] addr_next;
  logic          byte_last;
  logic          addr_last;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] m);
    if (m == MODE_PAGE) return {a[AW-1:PAGE_BITS], a[PAGE_BITS-1:0] + PAGE_BITS'(1)};
    return a + AW'(1);
  endfunction

  assign data_byte = {shift_in, si_level};
  assign addr_in   = {addr[AW-2:0], si_level};
  assign addr_next = next_addr(addr, mode);
  assign byte_last = (bit_cnt[2:0] == 3'd7);
  assign addr_last = (bit_cnt == 5'd23);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: combinational processes use blocking assignments with a default first,
  // so every path assigns state_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (ce_level) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (ce_fall) state_d = ST_CMD;
        ST_CMD:
          if (sclk_rise && byte_last) begin
            case (data_byte)
              CMD_READ, CMD_WRITE: state_d = ST_ADDR;
              CMD_RDMR:            state_d = ST_RDMR;
              CMD_WRMR:            state_d = ST_WRMR;
              default:             state_d = ST_IGNORE;
            endcase
          end
        ST_ADDR:  if (sclk_rise && addr_last) state_d = op_read ? ST_READ : ST_WRITE;
        ST_READ:  if (sclk_fall && byte_last && mode == MODE_BYTE) state_d = ST_IGNORE;
        ST_WRITE: if (sclk_rise && byte_last && mode == MODE_BYTE) state_d = ST_IGNORE;
        ST_RDMR:  if (sclk_fall && byte_last) state_d = ST_IGNORE;
        ST_WRMR:  if (sclk_rise && byte_last) state_d = ST_IGNORE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy  = (state_q != ST_IDLE);
    wr_en = (state_q == ST_WRITE) && sclk_rise && byte_last && !ce_level && !reset;
  end

  // Datapath: bits shift in on synced sclk rise, out on synced sclk fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode      <= MODE_SEQ;
      shift_in  <= '0;
      bit_cnt   <= '0;
      out_shift <= '0;
      addr      <= '0;
      op_read   <= 1'b0;
      so_q      <= 1'b0;
    end else if (ce_level || state_q == ST_IDLE) begin
      shift_in  <= '0;
      bit_cnt   <= '0;
      out_shift <= '0;
      so_q      <= 1'b0;
    end else if (sclk_rise) begin
      shift_in <= data_byte[6:0];
      case (state_q)
        ST_CMD: begin
          bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
          if (byte_last) begin
            op_read   <= (data_byte == CMD_READ);
            out_shift <= {mode, 6'b0};
          end
        end
        ST_ADDR: begin
          addr    <= addr_in;
          bit_cnt <= addr_last ? 5'd0 : bit_cnt + 5'd1;
          if (addr_last) out_shift <= mem[addr_in];
        end
        ST_WRITE, ST_WRMR: begin
          bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
          if (byte_last && state_q == ST_WRITE) addr <= addr_next;
          if (byte_last && state_q == ST_WRMR)  mode <= data_byte[7:6];
        end
        default: ;
      endcase
    end else if (sclk_fall) begin
      so_q <= 1'b0;
      if (state_q == ST_READ || state_q == ST_RDMR) begin
        so_q      <= out_shift[7];
        out_shift <= {out_shift[6:0], 1'b0};
        bit_cnt   <= {2'b00, bit_cnt[2:0] + 3'd1};
        if (state_q == ST_READ && byte_last) begin
          addr      <= addr_next;
          out_shift <= mem[addr_next];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= data_byte;
  end

  assign bd_data = mem[bd_addr];
  assign spi.so  = so_q;

endmodule

// File: tb/tb_spi_sram_target.sv
// Self-checking bench: SPI master tasks, table of write vectors, scoreboard of expected bytes.
module tb_spi_sram_target;
  import spi_sram_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int HALF  = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          busy;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_data;

  spi_sram_if spi_bus ();

  spi_sram_target #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .spi     (spi_bus),
    .busy    (busy),
    .bd_addr (bd_addr),
    .bd_data (bd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] val;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  typedef struct {
    string            name;
    logic [7:0]       mode;
    logic [23:0]      addr;
    int               nbytes;
    logic [31:0]      data;
    logic [0:3][9:0]  chk_addr;
    logic [0:3][7:0]  chk_data;
    int               nchk;
  } vec_t;
  vec_t vec[8];

  logic mon_en = 1'b0;
  int   so_high = 0;
  always @(negedge clk) if (mon_en && spi_bus.so) so_high++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_expect(input string name, input logic [7:0] val);
    sb_entry_t e;
    e.name = name;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input logic [7:0] act);
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got %0h expected none", act);
    end else begin
      e = sb_q.pop_front();
      check(e.name, {24'h0, act}, {24'h0, e.val});
    end
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_bus.si = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi_bus.so;
      spi_bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_bus.sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx);
    logic [7:0] rx;
    xfer_bits(tx, 8, rx);
  endtask

  task automatic begin_xfer();
    spi_bus.ce = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic end_xfer();
    repeat (HALF) @(negedge clk);
    spi_bus.ce = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_addr(input logic [23:0] a);
    xfer(a[23:16]);
    xfer(a[15:8]);
    xfer(a[7:0]);
  endtask

  task automatic wrmr(input logic [7:0] m);
    begin_xfer();
    xfer(CMD_WRMR);
    xfer(m);
    end_xfer();
  endtask

  task automatic rdmr(input string name, input logic [7:0] exp);
    logic [7:0] rx;
    begin_xfer();
    xfer(CMD_RDMR);
    sb_expect(name, exp);
    xfer_bits(8'h00, 8, rx);
    sb_compare(rx);
    end_xfer();
  endtask

  task automatic write_bytes(input logic [23:0] a, input int n, input logic [31:0] data);
    logic [31:0] d;
    d = data;
    begin_xfer();
    xfer(CMD_WRITE);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      xfer(d[31:24]);
      d = d << 8;
    end
    end_xfer();
  endtask

  task automatic read_bytes(input string name, input logic [23:0] a, input int n,
                            input logic [31:0] exp);
    logic [7:0] rx;
    begin_xfer();
    xfer(CMD_READ);
    check({name, "_busy"}, {31'h0, busy}, 32'h1);
    send_addr(a);
    for (int i = 0; i < n; i++) sb_expect(name, exp[31-8*i -: 8]);
    for (int i = 0; i < n; i++) begin
      xfer_bits(8'h00, 8, rx);
      sb_compare(rx);
    end
    end_xfer();
  endtask

  task automatic bd_check(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    sb_expect(name, exp);
    bd_addr = a;
    @(negedge clk);
    sb_compare(bd_data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;

    vec[0] = '{"seq_write",  8'h40, 24'h000010, 4, 32'hDEADBEEF,
               {10'h010, 10'h011, 10'h012, 10'h013}, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 4};
    vec[1] = '{"seq_wrap",   8'h40, 24'h0003FF, 2, 32'h11220000,
               {10'h3FF, 10'h000, 10'h000, 10'h000}, {8'h11, 8'h22, 8'h00, 8'h00}, 2};
    vec[2] = '{"alias",      8'h40, 24'h0013FF, 1, 32'h33000000,
               {10'h3FF, 10'h000, 10'h000, 10'h000}, {8'h33, 8'h22, 8'h00, 8'h00}, 2};
    vec[3] = '{"prep_lo",    8'h40, 24'h00001E, 4, 32'h0A0B0C0D,
               {10'h01E, 10'h01F, 10'h020, 10'h021}, {8'h0A, 8'h0B, 8'h0C, 8'h0D}, 4};
    vec[4] = '{"prep_hi",    8'h40, 24'h000040, 2, 32'h01020000,
               {10'h040, 10'h041, 10'h000, 10'h000}, {8'h01, 8'h02, 8'h00, 8'h00}, 2};
    vec[5] = '{"page_wrap",  8'h80, 24'h00001F, 3, 32'hC1C2C300,
               {10'h01F, 10'h000, 10'h001, 10'h020}, {8'hC1, 8'hC2, 8'hC3, 8'h0C}, 4};
    vec[6] = '{"byte_mode",  8'h00, 24'h000040, 2, 32'hAABB0000,
               {10'h040, 10'h041, 10'h000, 10'h000}, {8'hAA, 8'h02, 8'h00, 8'h00}, 2};
    vec[7] = '{"mode11_seq", 8'hC0, 24'h00007E, 3, 32'h71727300,
               {10'h07E, 10'h07F, 10'h080, 10'h000}, {8'h71, 8'h72, 8'h73, 8'h00}, 3};

    reset        = 1'b1;
    spi_bus.ce   = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.si   = 1'b0;
    bd_addr      = '0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_so", {31'h0, spi_bus.so}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);

    rdmr("rdmr_after_reset", 8'h40);

    for (int v = 0; v < 8; v++) begin
      wrmr(vec[v].mode);
      rdmr({vec[v].name, "_mode"}, vec[v].mode & 8'hC0);
      write_bytes(vec[v].addr, vec[v].nbytes, vec[v].data);
      for (int k = 0; k < vec[v].nchk; k++)
        bd_check(vec[v].name, vec[v].chk_addr[k], vec[v].chk_data[k]);
    end

    read_bytes("seq_read", 24'h000010, 4, 32'hDEADBEEF);

    // Illegal opcode followed by 16 clocks: so stays low, array untouched.
    begin_xfer();
    mon_en = 1'b1;
    xfer(8'h9F);
    xfer_bits(8'hFF, 8, rx);
    check("illegal_rx0", {24'h0, rx}, 32'h0);
    check("illegal_busy", {31'h0, busy}, 32'h1);
    xfer_bits(8'hFF, 8, rx);
    check("illegal_rx1", {24'h0, rx}, 32'h0);
    mon_en = 1'b0;
    end_xfer();
    check("illegal_so_high", so_high, 0);
    bd_check("illegal_mem10", 10'h010, 8'hDE);
    bd_check("illegal_mem7e", 10'h07E, 8'h71);

    // Reset in the middle of a READ.
    wrmr(8'h80);
    rdmr("rdmr_page", 8'h80);
    begin_xfer();
    xfer(CMD_READ);
    send_addr(24'h000010);
    repeat (HALF - 1) @(negedge clk);
    check("midread_so_msb", {31'h0, spi_bus.so}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("midread_reset_so", {31'h0, spi_bus.so}, 32'h0);
    check("midread_reset_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    xfer_bits(8'h00, 8, rx);
    check("after_reset_rx", {24'h0, rx}, 32'h0);
    check("after_reset_busy", {31'h0, busy}, 32'h0);
    end_xfer();
    rdmr("rdmr_reset_mode", 8'h40);

    // Abort a write mid-byte.
    begin_xfer();
    xfer(CMD_WRITE);
    send_addr(24'h000020);
    xfer(8'h5A);
    xfer_bits(8'hFF, 4, rx);
    repeat (HALF) @(negedge clk);
    spi_bus.ce = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_busy_held", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("abort_busy_drop", {31'h0, busy}, 32'h0);
    check("abort_so", {31'h0, spi_bus.so}, 32'h0);
    repeat (4) @(negedge clk);
    bd_check("abort_mem20", 10'h020, 8'h5A);
    bd_check("abort_mem21", 10'h021, 8'h0D);

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
